// File: rtl/line_buff_fill.sv
// Fill engine for the two display line buffers: on each fill request it streams one
// tile row from the frame buffer into the selected line buffer and pulses fill-done.
module line_buff_fill #(
  parameter int WIDTH_PX       = 640,
  parameter int HEIGHT_LNS     = 480,
  parameter int TILE_WIDTH     = 4,
  parameter int PXL_WIDTH      = 12,
  parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_ROWS      = HEIGHT_LNS / TILE_WIDTH,
  parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
  parameter int FB_ADDR_WIDTH  = $clog2(TILE_PER_LINE * TILE_ROWS)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [1:0]                buff_fill_req_i,
  input  logic                      frame_sync_i,
  output logic                      fb_rd_req_o,
  input  logic                      fb_gnt_i,
  output logic [FB_ADDR_WIDTH-1:0]  fb_addr_o,
  input  logic [PXL_WIDTH-1:0]      fb_rdata_i,
  output logic [1:0]                lb_we_o,
  output logic [TILE_CTR_WIDTH-1:0] lb_addr_o,
  output logic [PXL_WIDTH-1:0]      lb_wdata_o,
  output logic [1:0]                buff_fill_done_o,
  output logic                      busy_o
);

  localparam int ROW_WIDTH = $clog2(TILE_ROWS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                state_r;
  logic [ROW_WIDTH-1:0]      row_r;
  logic [TILE_CTR_WIDTH-1:0] rd_idx_r;
  logic [TILE_CTR_WIDTH-1:0] wr_idx_r;
  logic                      sel_r;
  logic                      sync_pend_r;
  logic                      wr_vld_r;
  logic                      rd_acc_s;
  logic                      last_rd_s;
  logic [1:0]                sel_onehot_s;
  logic [FB_ADDR_WIDTH-1:0]  rd_addr_s;

  assign rd_acc_s     = (state_r == ST_READ) && fb_gnt_i;
  assign last_rd_s    = (rd_idx_r == TILE_CTR_WIDTH'(TILE_PER_LINE - 1));
  assign sel_onehot_s = sel_r ? 2'b10 : 2'b01;
  // Widen before multiplying so the row base never truncates.
  assign rd_addr_s    = FB_ADDR_WIDTH'(row_r) * FB_ADDR_WIDTH'(TILE_PER_LINE)
                      + FB_ADDR_WIDTH'(rd_idx_r);
  assign lb_wdata_o   = fb_rdata_i;

  // Fill sequencing, tile-row tracking and deferred frame sync.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      row_r       <= {ROW_WIDTH{1'b0}};
      rd_idx_r    <= {TILE_CTR_WIDTH{1'b0}};
      sel_r       <= 1'b0;
      sync_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_sync_i) begin
            row_r <= {ROW_WIDTH{1'b0}};
          end
          if (buff_fill_req_i != 2'b00) begin
            sel_r    <= ~buff_fill_req_i[0];
            rd_idx_r <= {TILE_CTR_WIDTH{1'b0}};
            state_r  <= ST_READ;
          end
        end
        ST_READ: begin
          if (frame_sync_i) begin
            sync_pend_r <= 1'b1;
          end
          if (fb_gnt_i) begin
            if (last_rd_s) begin
              state_r <= ST_DRAIN;
            end else begin
              rd_idx_r <= rd_idx_r + TILE_CTR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (frame_sync_i) begin
            sync_pend_r <= 1'b1;
          end
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          sync_pend_r <= 1'b0;
          // A sync landing in this very cycle still counts for the next fill.
          if (sync_pend_r || frame_sync_i) begin
            row_r <= {ROW_WIDTH{1'b0}};
          end else if (row_r == ROW_WIDTH'(TILE_ROWS - 1)) begin
            row_r <= {ROW_WIDTH{1'b0}};
          end else begin
            row_r <= row_r + ROW_WIDTH'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Write-back: each accepted read is written one cycle later when its data arrives.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_vld_r <= 1'b0;
      wr_idx_r <= {TILE_CTR_WIDTH{1'b0}};
    end else begin
      wr_vld_r <= rd_acc_s;
      if (rd_acc_s) begin
        wr_idx_r <= rd_idx_r;
      end else begin
        wr_idx_r <= wr_idx_r;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    fb_rd_req_o      = 1'b0;
    fb_addr_o        = {FB_ADDR_WIDTH{1'b0}};
    buff_fill_done_o = 2'b00;
    busy_o           = 1'b1;
    lb_addr_o        = wr_idx_r;
    if (wr_vld_r) begin
      lb_we_o = sel_onehot_s;
    end else begin
      lb_we_o = 2'b00;
    end
    case (state_r)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_READ: begin
        fb_rd_req_o = 1'b1;
        fb_addr_o   = rd_addr_s;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
      end
      ST_DONE: begin
        buff_fill_done_o = sel_onehot_s;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_line_buff_fill.sv
// Self-checking bench for line_buff_fill: table of fill scenarios, scoreboard queues of
// expected reads/writes/done pulses, plus row-wrap and reset-abort sequences.
module tb_line_buff_fill;

  localparam int TPL = 160;
  localparam int AW  = 15;
  localparam int CW  = 8;
  localparam int PW  = 12;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [1:0]    buff_fill_req_i;
  logic          frame_sync_i;
  logic          fb_rd_req_o;
  logic          fb_gnt_i;
  logic [AW-1:0] fb_addr_o;
  logic [PW-1:0] fb_rdata_i = '0;
  logic [1:0]    lb_we_o;
  logic [CW-1:0] lb_addr_o;
  logic [PW-1:0] lb_wdata_o;
  logic [1:0]    buff_fill_done_o;
  logic          busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] addr_q[$];
  logic [21:0]   wr_q[$];
  logic [1:0]    done_q[$];

  typedef struct {
    logic [1:0] req;
    bit         sync_req;
    bit         stall;
    int         sync_at;
    int         base;
    logic [1:0] done;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  line_buff_fill dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .buff_fill_req_i  (buff_fill_req_i),
    .frame_sync_i     (frame_sync_i),
    .fb_rd_req_o      (fb_rd_req_o),
    .fb_gnt_i         (fb_gnt_i),
    .fb_addr_o        (fb_addr_o),
    .fb_rdata_i       (fb_rdata_i),
    .lb_we_o          (lb_we_o),
    .lb_addr_o        (lb_addr_o),
    .lb_wdata_o       (lb_wdata_o),
    .buff_fill_done_o (buff_fill_done_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [PW-1:0] pix(input int a);
    return PW'(a * 37 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Frame buffer model: data one cycle after an accepted read.
  always @(posedge clk_i) begin
    if (fb_rd_req_o && fb_gnt_i) fb_rdata_i <= pix(int'(fb_addr_o));
  end

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (fb_rd_req_o) begin
        if (addr_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else begin
          chk("fb_addr", 32'(fb_addr_o), 32'(addr_q[0]));
          if (fb_gnt_i) void'(addr_q.pop_front());
        end
      end
      if (lb_we_o != 2'b00) begin
        if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else chk("lb_write", 32'({lb_we_o, lb_addr_o, lb_wdata_o}), 32'(wr_q.pop_front()));
      end
      if (buff_fill_done_o != 2'b00) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_bits", 32'(buff_fill_done_o), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic do_fill(input logic [1:0] req, input bit sync_req, input bit stall,
                         input int sync_at, input int base, input logic [1:0] done,
                         input int lat, input int abort_at);
    int cyc;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < TPL; i++) begin
      addr_q.push_back(AW'(base + i));
      wr_q.push_back({done, CW'(i), pix(base + i)});
    end
    done_q.push_back(done);
    buff_fill_req_i = req;
    frame_sync_i    = sync_req;
    @(posedge clk_i); #1;
    buff_fill_req_i = 2'b00;
    frame_sync_i    = 1'b0;
    cyc = 1;
    while (!seen && cyc <= lat + 20) begin
      if (cyc == abort_at) begin
        rstn_i = 1'b0;
        #1;
        chk("abort_outputs_zero",
            32'({fb_rd_req_o, busy_o, lb_we_o, buff_fill_done_o, lb_addr_o, fb_addr_o}), 32'd0);
        addr_q.delete();
        wr_q.delete();
        done_q.delete();
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          chk("abort_no_done", 32'({buff_fill_done_o, busy_o}), 32'd0);
        end
        @(posedge clk_i); #1;
        rstn_i   = 1'b1;
        fb_gnt_i = 1'b1;
        return;
      end
      fb_gnt_i     = stall ? cyc[0] : 1'b1;
      frame_sync_i = (cyc == sync_at);
      @(negedge clk_i);
      if (buff_fill_done_o != 2'b00) seen = 1'b1;
      else begin
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    chk("done_latency", 32'(cyc), 32'(lat));
    @(posedge clk_i); #1;
    fb_gnt_i     = 1'b1;
    frame_sync_i = 1'b0;
    chk("idle_after_done", 32'(busy_o), 32'd0);
    chk("queues_drained", 32'(addr_q.size() + wr_q.size() + done_q.size()), 32'd0);
    addr_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b01, 1'b0, 1'b0, 0,  0,   2'b01, 162};
    tbl[1] = '{2'b10, 1'b0, 1'b1, 0,  160, 2'b10, 321};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 0,  320, 2'b01, 162};
    tbl[3] = '{2'b10, 1'b1, 1'b0, 0,  0,   2'b10, 162};
    tbl[4] = '{2'b01, 1'b0, 1'b0, 0,  160, 2'b01, 162};
    tbl[5] = '{2'b10, 1'b0, 1'b0, 0,  320, 2'b10, 162};
    tbl[6] = '{2'b01, 1'b0, 1'b0, 0,  480, 2'b01, 162};
    tbl[7] = '{2'b10, 1'b0, 1'b0, 0,  640, 2'b10, 162};
    tbl[8] = '{2'b01, 1'b0, 1'b0, 40, 800, 2'b01, 162};
    tbl[9] = '{2'b10, 1'b0, 1'b0, 0,  0,   2'b10, 162};

    rstn_i          = 1'b0;
    buff_fill_req_i = 2'b00;
    frame_sync_i    = 1'b0;
    fb_gnt_i        = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs_zero",
        32'({fb_rd_req_o, busy_o, lb_we_o, buff_fill_done_o, lb_addr_o, fb_addr_o}), 32'd0);
    chk("reset_wdata_zero", 32'(lb_wdata_o), 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("post_reset_idle", 32'({busy_o, fb_rd_req_o}), 32'd0);
    end
    @(posedge clk_i); #1;

    for (int t = 0; t < 10; t++) begin
      do_fill(tbl[t].req, tbl[t].sync_req, tbl[t].stall, tbl[t].sync_at,
              tbl[t].base, tbl[t].done, tbl[t].lat, 0);
    end

    // Lone frame sync in IDLE, then a full frame of fills plus one to show the wrap.
    frame_sync_i = 1'b1;
    @(posedge clk_i); #1;
    frame_sync_i = 1'b0;
    for (int i = 0; i <= 120; i++) begin
      do_fill(i[0] ? 2'b10 : 2'b01, 1'b0, 1'b0, 0, (i % 120) * TPL,
              i[0] ? 2'b10 : 2'b01, 162, 0);
    end

    do_fill(2'b01, 1'b0, 1'b0, 0, 160, 2'b01, 162, 30);
    do_fill(2'b10, 1'b0, 1'b0, 0, 0, 2'b10, 162, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
